// File: rtl/neuron_lut_loader.sv
// Runtime-loadable neuron truth table: a word-wide config stream fills a 2^IN_BITS x OUT_BITS RAM, and M0 looks it up.
// Latency: 1 cycle M0 -> M1. A config word is written in the cycle it is accepted.
// Backpressure: cfg_ready is high only while loading. Words offered outside a load are dropped and flagged on cfg_err.
//
// Ports: clk/rst (synchronous, active-high); cfg_start/cfg_valid/cfg_ready/cfg_data form the config stream;
//        cfg_done/cfg_err are one-cycle event pulses; lut_valid marks a complete resident table;
//        M0 is the lookup address and M1 is the registered entry (0 while no table is resident).
module neuron_lut_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 2,
    parameter int CFG_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic                lut_valid,
    input  logic [IN_BITS-1:0]  M0,
    output logic [OUT_BITS-1:0] M1
);

    localparam int DEPTH = 1 << IN_BITS;
    localparam int E     = CFG_W / OUT_BITS;   // entries per config word
    localparam int NW    = DEPTH / E;          // words per table
    localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_READY
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [OUT_BITS-1:0] m1_q;

    logic [OUT_BITS-1:0] mem [DEPTH];

    logic               accept;
    logic               last_word;
    logic [IN_BITS-1:0] wr_base;

    // A start in LOAD takes priority over a concurrent word, so that word is not accepted.
    assign accept    = (state_q == S_LOAD) && cfg_valid && !cfg_start;
    assign last_word = (cnt_q == CNT_W'(NW - 1));
    assign wr_base   = IN_BITS'(cnt_q) * IN_BITS'(E);

    assign cfg_ready = (state_q == S_LOAD);
    assign lut_valid = (state_q == S_READY);
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign M1        = m1_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE, S_READY: begin
                if (cfg_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else if (cfg_valid) begin
                    err_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (accept) begin
                    if (last_word) begin
                        state_d = S_READY;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Table storage has no reset; a whole word's worth of entries lands in one cycle.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            for (int k = 0; k < E; k++) begin
                mem[wr_base + IN_BITS'(k)] <= cfg_data[k*OUT_BITS +: OUT_BITS];
            end
        end
    end

    // Lookups return 0 unless a complete table is resident, so a partial load is never visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            m1_q <= '0;
        end else begin
            m1_q <= lut_valid ? mem[M0] : '0;
        end
    end

endmodule

// File: tb/tb_neuron_lut_loader.sv
module tb_neuron_lut_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;
    logic        cfg_done;
    logic        cfg_err;
    logic        lut_valid;
    logic [7:0]  M0;
    logic [1:0]  M1;

    int tests = 0;
    int fails = 0;

    logic [1:0] exp_q[$];
    logic       look_vld = 1'b0;
    logic       look_d   = 1'b0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         acc_cnt  = 0;

    neuron_lut_loader #(.IN_BITS(8), .OUT_BITS(2), .CFG_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .lut_valid (lut_valid),
        .M0        (M0),
        .M1        (M1)
    );

    always #5 clk = ~clk;

    // Track which edges carried a lookup, and count handshakes.
    always @(posedge clk) begin
        look_d <= look_vld;
        if (cfg_valid && cfg_ready) acc_cnt <= acc_cnt + 1;
    end

    // Monitor: M1 for a lookup issued before edge t is compared half a cycle after t.
    always @(negedge clk) begin
        logic [1:0] e;
        if (cfg_done) done_cnt++;
        if (cfg_err)  err_cnt++;
        if (look_d) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: M1=%0d with no expected entry", M1);
            end else begin
                e = exp_q.pop_front();
                if (M1 !== e) begin
                    fails++;
                    $display("FAIL lookup: M1=%0d expected %0d", M1, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // mode 0: all zero, 1: (M0>>4)&3, 2: 2'b01 everywhere
    task automatic sweep(input int mode);
        logic [1:0] e;
        for (int a = 0; a < 256; a++) begin
            M0 = 8'(a);
            case (mode)
                1:       e = 2'((a >> 4) & 3);
                2:       e = 2'b01;
                default: e = 2'b00;
            endcase
            exp_q.push_back(e);
            look_vld = 1'b1;
            tick();
        end
        look_vld = 1'b0;
        tick();
        tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // mode 1: every field = w[1:0], 2: 0x55555555, else all ones
    task automatic send_words(input int n, input int mode, input bit stall);
        logic [1:0] wb;
        for (int w = 0; w < n; w++) begin
            if (stall) begin
                cfg_valid = 1'b0;
                tick();
            end
            wb = 2'(w);
            cfg_valid = 1'b1;
            case (mode)
                1:       cfg_data = {16{wb}};
                2:       cfg_data = 32'h5555_5555;
                default: cfg_data = 32'hFFFF_FFFF;
            endcase
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        int d0, e0, a0;
        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; M0 = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state and idle lookups
        check("rst_ready", cfg_ready, 0);
        check("rst_lut_valid", lut_valid, 0);
        check("rst_done", cfg_done, 0);
        check("rst_err", cfg_err, 0);
        check("rst_m1", M1, 0);
        repeat (5) tick();
        check("idle_ready", cfg_ready, 0);
        sweep(0);

        // Unstalled load
        d0 = done_cnt;
        start_load();
        check("load_ready", cfg_ready, 1);
        check("load_lut_valid", lut_valid, 0);
        send_words(16, 1, 1'b0);
        check("done_after_last", cfg_done, 1);
        check("lut_valid_after_last", lut_valid, 1);
        check("ready_after_last", cfg_ready, 0);
        tick();
        check("done_one_cycle", cfg_done, 0);
        check("done_count_1", 32'(done_cnt - d0), 1);
        sweep(1);

        // Stalled load
        d0 = done_cnt;
        start_load();
        a0 = acc_cnt;
        send_words(16, 1, 1'b1);
        check("stall_done", cfg_done, 1);
        tick();
        check("stall_accepts", 32'(acc_cnt - a0), 16);
        check("stall_done_count", 32'(done_cnt - d0), 1);
        sweep(1);

        // Unsolicited word in READY
        e0 = err_cnt;
        cfg_valid = 1'b1;
        cfg_data  = 32'hFFFF_FFFF;
        tick();
        cfg_valid = 1'b0;
        check("err_pulse", cfg_err, 1);
        check("err_lut_valid", lut_valid, 1);
        tick();
        check("err_one_cycle", cfg_err, 0);
        check("err_count_1", 32'(err_cnt - e0), 1);
        sweep(1);

        // Restart mid-load, start wins over a concurrent word
        e0 = err_cnt;
        start_load();
        send_words(7, 3, 1'b0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 32'hFFFF_FFFF;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        check("restart_no_err", cfg_err, 0);
        check("restart_ready", cfg_ready, 1);
        check("restart_lut_valid", lut_valid, 0);
        d0 = done_cnt;
        send_words(16, 2, 1'b0);
        tick();
        check("restart_done_count", 32'(done_cnt - d0), 1);
        check("restart_err_count", 32'(err_cnt - e0), 0);
        sweep(2);

        // Reset mid-load, then a full reload
        start_load();
        send_words(10, 1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_lut_valid", lut_valid, 0);
        check("midrst_ready", cfg_ready, 0);
        check("midrst_m1", M1, 0);
        sweep(0);
        start_load();
        send_words(16, 1, 1'b0);
        check("reload_lut_valid", lut_valid, 1);
        sweep(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/neuron_lut_loader.md
Name: neuron_lut_loader

Overview:
- Runtime-programmable counterpart of the fixed neuron truth-table ROMs.
- Writes a 2^IN_BITS x OUT_BITS truth table from a word-wide configuration stream into distributed RAM.
- Once a complete table is loaded, serves neuron lookups with the same M0 -> M1 interface as a ROM neuron.
- Sits between the host configuration bus and a layer slot, so neurons can be reprogrammed without re-synthesis.

Parameters:
IN_BITS, 8, lookup address width (table depth = 2^IN_BITS)
OUT_BITS, 2, table entry width
CFG_W, 32, config word width; must be a multiple of OUT_BITS, and CFG_W/OUT_BITS must divide 2^IN_BITS

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cfg_start  input  1  begin (re)load of the full table
cfg_valid  input  1  cfg_data valid
cfg_ready  output  1  loader accepts a word this cycle
cfg_data  input  CFG_W  packed table entries
cfg_done  output  1  one-cycle pulse when the last word is written
cfg_err  output  1  one-cycle pulse when an unsolicited word is dropped
lut_valid  output  1  a complete table is resident
M0  input  IN_BITS  lookup address
M1  output  OUT_BITS  registered lookup result

Behaviour:
- Derived constants: E = CFG_W/OUT_BITS entries per word; NW = 2^IN_BITS/E words per table. Defaults: E=16, NW=16.
- Reset (rst=1 at an edge):
  - state=IDLE, word counter=0.
  - cfg_ready=0, cfg_done=0, cfg_err=0, lut_valid=0, M1=0.
  - Table RAM contents are not reset and are undefined.
- State IDLE:
  - cfg_ready=0.
  - cfg_start -> LOAD, counter=0.
  - cfg_valid without cfg_start -> cfg_err=1 next cycle; word dropped.
- State LOAD:
  - cfg_ready=1; lut_valid=0 from the first LOAD cycle.
  - On cfg_valid & cfg_ready, word w = counter is written; entry k occupies cfg_data[k*OUT_BITS +: OUT_BITS] and goes to address w*E+k, for k=0..E-1. All E entries are written in one cycle.
  - Counter increments per accepted word, no wrap.
  - Accepting word NW-1 -> READY next cycle, with cfg_done=1 and lut_valid=1 in that same cycle.
  - cfg_start in LOAD restarts at counter=0. In that cycle cfg_start has priority and the concurrent word is not accepted; cfg_ready stays 1 but the handshake is ignored, and no cfg_err is raised.
  - cfg_valid=0 stalls indefinitely; there is no timeout.
- State READY:
  - cfg_ready=0, lut_valid=1.
  - cfg_start -> LOAD, counter=0, lut_valid=0 next cycle.
  - cfg_valid without cfg_start -> cfg_err pulse; word dropped.
- cfg_start together with cfg_valid in IDLE or READY: start wins, no cfg_err, word not written.
- Lookup path:
  - Latency 1: M1 at edge t+1 = table[M0 at t] when lut_valid at t is 1, else 0.
  - A read of an address written in the same cycle cannot occur, because lut_valid=0 throughout LOAD.
- Reset mid-LOAD: returns to IDLE, lut_valid=0. A partial table is never exposed; a full reload is required.
- cfg_done and cfg_err each assert for exactly one cycle per event and never together.

Test Plan:
- Reset, then idle 5 cycles -> cfg_ready=0, lut_valid=0, M1=2'b00 for every M0.
- cfg_start, then 16 words where word w has every 2-bit field = w[1:0]; sweep M0 0..255 -> M1 = (M0>>4)&3, one cycle after each M0; cfg_done pulses exactly once, in the cycle after word 15.
- Load with cfg_valid toggling 1,0,1,0 -> 16 accepted words over 32 cycles, same table contents as the unstalled load; cfg_done only after the 16th acceptance.
- In READY, drive cfg_valid=1 with data 0xFFFFFFFF and no start -> cfg_err pulses one cycle; lookups are unchanged.
- Start a load of all-ones, assert cfg_start after 7 words, then send 16 words of 0x55555555 -> M1=2'b01 for all addresses.
- Assert rst after 10 words -> lut_valid=0 and M1=0; the following full load succeeds and matches the expected table.
